// File: rtl/spi_pkg.sv
// Shared types and command codes for the SPI frame loader.
// Holds the loader FSM state encoding and the one-byte command opcodes.
// Imported by the loader top and its address counter.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      LOAD  = 2'd2,
      DRAIN = 2'd3
   } loaderState_t;

   localparam logic [7:0] LOAD_CMD  = 8'hA5;
   localparam logic [7:0] START_CMD = 8'h5A;

endpackage

// File: rtl/frame_addr_counter.sv
// Raster-order pixel address counter with clear, increment and terminal count.
// Latency: count updates on the clock edge after clear/inc.
// Saturates at lastAddr: an increment at terminal count is ignored, never wraps.
module frame_addr_counter #(
   parameter int addrBits = 12,
   parameter int lastAddr = 4095
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                inc,
   output logic [addrBits-1:0] count,
   output logic                term
);
   import spi_pkg::*;

   localparam logic [addrBits-1:0] lastVal = addrBits'(lastAddr);

   assign term = (count == lastVal);

   // Clear has priority; increment stops at the final address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && !term) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/spi_frame_loader.sv
// Steers SPI bytes into the frame buffer after a one-byte command; tracks frame validity and starts the edge engine.
// Latency: accepted pixel byte to bufWe is 1 cycle; START command byte to engineStart is 1 cycle.
// No backpressure: bytes that cannot be used (drain, busy engine) are dropped and flagged in errOverrun.
module spi_frame_loader #(
   parameter int imgWidth  = 64,
   parameter int imgHeight = 64,
   parameter int addrBits  = 12,
   parameter int dataBits  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                byteValid,
   input  logic [dataBits-1:0] rxByte,
   input  logic                csActive,
   input  logic                engineBusy,
   input  logic                errClear,
   output logic                bufWe,
   output logic [addrBits-1:0] bufAddr,
   output logic [dataBits-1:0] bufData,
   output logic                frameValid,
   output logic                engineStart,
   output logic                loading,
   output logic                errAbort,
   output logic                errOverrun,
   output logic                errStart
);
   import spi_pkg::*;

   localparam int numPixels = imgWidth * imgHeight;

   loaderState_t        state;
   loaderState_t        next_state;
   logic                cs_q;
   logic [addrBits-1:0] pix_cnt;
   logic                pix_term;

   // Decoded per-cycle actions produced by the output process.
   logic wr_pix;
   logic clr_cnt;
   logic clr_fv;
   logic start_req;
   logic set_ovr;
   logic set_serr;
   logic set_abort;

   logic is_load_cmd;
   logic is_start_cmd;

   assign is_load_cmd  = (rxByte == dataBits'(LOAD_CMD));
   assign is_start_cmd = (rxByte == dataBits'(START_CMD));

   frame_addr_counter #(
      .addrBits (addrBits),
      .lastAddr (numPixels - 1)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clr_cnt),
      .inc   (wr_pix),
      .count (pix_cnt),
      .term  (pix_term)
   );

   // State register plus delayed chip-select for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cs_q  <= 1'b0;
      end else begin
         state <= next_state;
         cs_q  <= csActive;
      end
   end

   // Next-state: a byte arriving with a cs drop is handled first, the drop is seen next cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (csActive && !cs_q) next_state = CMD;
         end
         CMD: begin
            if (byteValid) begin
               if (is_load_cmd && !engineBusy) next_state = LOAD;
               else                            next_state = DRAIN;
            end else if (!csActive) begin
               next_state = IDLE;
            end
         end
         LOAD: begin
            if (byteValid) begin
               if (pix_term) next_state = DRAIN;
            end else if (!csActive) begin
               next_state = IDLE;
            end
         end
         DRAIN: begin
            if (!byteValid && !csActive) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output decode: which writes, counter ops and flag sets happen this cycle.
   always_comb begin
      wr_pix    = 1'b0;
      clr_cnt   = 1'b0;
      clr_fv    = 1'b0;
      start_req = 1'b0;
      set_ovr   = 1'b0;
      set_serr  = 1'b0;
      set_abort = 1'b0;
      case (state)
         CMD: begin
            if (byteValid) begin
               if (is_load_cmd) begin
                  if (engineBusy) begin
                     set_ovr = 1'b1;
                  end else begin
                     clr_cnt = 1'b1;
                     clr_fv  = 1'b1;
                  end
               end else if (is_start_cmd) begin
                  if (frameValid && !engineBusy) start_req = 1'b1;
                  else                           set_serr  = 1'b1;
               end
            end
         end
         LOAD: begin
            if (byteValid)      wr_pix    = 1'b1;
            else if (!csActive) set_abort = 1'b1;
         end
         DRAIN: begin
            if (byteValid) set_ovr = 1'b1;
         end
         default: ;
      endcase
   end

   assign loading = (state == LOAD);

   // Registered buffer write port; address/data hold their last written value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bufWe   <= 1'b0;
         bufAddr <= '0;
         bufData <= '0;
      end else begin
         bufWe <= wr_pix;
         if (wr_pix) begin
            bufAddr <= pix_cnt;
            bufData <= rxByte;
         end
      end
   end

   // Frame validity rises with the final pixel write; engine start is a guarded single pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frameValid  <= 1'b0;
         engineStart <= 1'b0;
      end else begin
         if (clr_fv)                  frameValid <= 1'b0;
         else if (wr_pix && pix_term) frameValid <= 1'b1;
         engineStart <= start_req && !engineStart;
      end
   end

   // Sticky error flags; a clear wins over a set in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         errAbort   <= 1'b0;
         errOverrun <= 1'b0;
         errStart   <= 1'b0;
      end else if (errClear) begin
         errAbort   <= 1'b0;
         errOverrun <= 1'b0;
         errStart   <= 1'b0;
      end else begin
         if (set_abort) errAbort   <= 1'b1;
         if (set_ovr)   errOverrun <= 1'b1;
         if (set_serr)  errStart   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader with a 4x2 frame.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A monitor logs every buffer write into queues for per-scenario checking.
module tb_spi_frame_loader;
   import spi_pkg::*;

   logic        clk;
   logic        rst;
   logic        byteValid;
   logic [7:0]  rxByte;
   logic        csActive;
   logic        engineBusy;
   logic        errClear;
   logic        bufWe;
   logic [11:0] bufAddr;
   logic [7:0]  bufData;
   logic        frameValid;
   logic        engineStart;
   logic        loading;
   logic        errAbort;
   logic        errOverrun;
   logic        errStart;

   int n_checks;
   int n_fail;
   int n_starts;

   logic [11:0] wq_addr[$];
   logic [7:0]  wq_data[$];

   spi_frame_loader #(
      .imgWidth  (4),
      .imgHeight (2),
      .addrBits  (12),
      .dataBits  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .byteValid   (byteValid),
      .rxByte      (rxByte),
      .csActive    (csActive),
      .engineBusy  (engineBusy),
      .errClear    (errClear),
      .bufWe       (bufWe),
      .bufAddr     (bufAddr),
      .bufData     (bufData),
      .frameValid  (frameValid),
      .engineStart (engineStart),
      .loading     (loading),
      .errAbort    (errAbort),
      .errOverrun  (errOverrun),
      .errStart    (errStart)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write/start monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (bufWe) begin
         wq_addr.push_back(bufAddr);
         wq_data.push_back(bufData);
      end
      if (engineStart) n_starts++;
   end

   task automatic send_byte(input logic [7:0] b);
      byteValid = 1'b1;
      rxByte    = b;
      @(negedge clk);
      byteValid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_on();
      csActive = 1'b1;
      @(negedge clk);
   endtask

   task automatic cs_off();
      csActive = 1'b0;
      idle(2);
   endtask

   task automatic clear_errs();
      errClear = 1'b1;
      @(negedge clk);
      errClear = 1'b0;
   endtask

   task automatic clear_log();
      wq_addr.delete();
      wq_data.delete();
   endtask

   task automatic do_full_load();
      cs_on();
      send_byte(8'hA5);
      for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      n_checks++;
      if ({bufWe, bufAddr, bufData, frameValid, engineStart, loading, errAbort, errOverrun, errStart} !== 28'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got we=%b addr=%h data=%h fv=%b st=%b ld=%b ea=%b eo=%b es=%b, required all 0",
                  bufWe, bufAddr, bufData, frameValid, engineStart, loading, errAbort, errOverrun, errStart);
      end
      n_checks++;
      if (dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got %0d required IDLE", dut.state);
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_full_load();
      clear_log();
      cs_on();
      send_byte(8'hA5);
      n_checks++;
      if (loading !== 1'b1) begin
         n_fail++;
         $display("FAIL load_enter: loading=%b required 1", loading);
      end
      for (int i = 0; i < 7; i++) send_byte(8'h10 + 8'(i));
      n_checks++;
      if (frameValid !== 1'b0) begin
         n_fail++;
         $display("FAIL fv_early: frameValid=%b required 0 after 7 pixels", frameValid);
      end
      send_byte(8'h17);
      n_checks++;
      if ({bufWe, frameValid, bufAddr, bufData} !== {1'b1, 1'b1, 12'd7, 8'h17}) begin
         n_fail++;
         $display("FAIL last_write: we=%b fv=%b addr=%h data=%h required we=1 fv=1 addr=007 data=17",
                  bufWe, frameValid, bufAddr, bufData);
      end
      idle(1);
      n_checks++;
      if (dut.state !== DRAIN || loading !== 1'b0) begin
         n_fail++;
         $display("FAIL load_exit: state=%0d loading=%b required DRAIN/0", dut.state, loading);
      end
      n_checks++;
      if (wq_addr.size() !== 8) begin
         n_fail++;
         $display("FAIL load_count: %0d writes required 8", wq_addr.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (wq_addr[i] !== 12'(i) || wq_data[i] !== 8'h10 + 8'(i)) begin
               n_fail++;
               $display("FAIL load_write%0d: addr=%h data=%h required addr=%h data=%h",
                        i, wq_addr[i], wq_data[i], 12'(i), 8'h10 + 8'(i));
            end
         end
      end
      cs_off();
      n_checks++;
      if (dut.state !== IDLE || {errAbort, errOverrun, errStart} !== 3'b000 || frameValid !== 1'b1) begin
         n_fail++;
         $display("FAIL load_done: state=%0d errs=%b%b%b fv=%b required IDLE 000 fv=1",
                  dut.state, errAbort, errOverrun, errStart, frameValid);
      end
   endtask

   task automatic test_start();
      n_starts = 0;
      cs_on();
      send_byte(8'h5A);
      n_checks++;
      if (engineStart !== 1'b1) begin
         n_fail++;
         $display("FAIL start_pulse: engineStart=%b required 1", engineStart);
      end
      idle(1);
      n_checks++;
      if (engineStart !== 1'b0) begin
         n_fail++;
         $display("FAIL start_single: engineStart=%b required 0 one cycle later", engineStart);
      end
      cs_off();
      n_checks++;
      if (n_starts !== 1 || errStart !== 1'b0) begin
         n_fail++;
         $display("FAIL start_count: pulses=%0d errStart=%b required 1 pulse, errStart 0", n_starts, errStart);
      end
      engineBusy = 1'b1;
      cs_on();
      send_byte(8'h5A);
      idle(1);
      n_checks++;
      if (n_starts !== 1 || errStart !== 1'b1) begin
         n_fail++;
         $display("FAIL start_busy: pulses=%0d errStart=%b required 1 pulse total, errStart 1", n_starts, errStart);
      end
      engineBusy = 1'b0;
      cs_off();
      clear_errs();
      n_checks++;
      if (errStart !== 1'b0) begin
         n_fail++;
         $display("FAIL start_clear: errStart=%b required 0", errStart);
      end
   endtask

   task automatic test_abort();
      clear_log();
      cs_on();
      send_byte(8'hA5);
      send_byte(8'h21);
      send_byte(8'h22);
      send_byte(8'h23);
      cs_off();
      n_checks++;
      if (errAbort !== 1'b1 || frameValid !== 1'b0 || dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL abort_flags: errAbort=%b fv=%b state=%0d required 1/0/IDLE", errAbort, frameValid, dut.state);
      end
      n_checks++;
      if (wq_addr.size() !== 3) begin
         n_fail++;
         $display("FAIL abort_count: %0d writes required 3", wq_addr.size());
      end else if (wq_addr[0] !== 12'd0 || wq_addr[1] !== 12'd1 || wq_addr[2] !== 12'd2) begin
         n_fail++;
         $display("FAIL abort_count: addrs %h %h %h required 000 001 002", wq_addr[0], wq_addr[1], wq_addr[2]);
      end
      clear_errs();
      cs_on();
      send_byte(8'hA5);
      send_byte(8'h55);
      n_checks++;
      if ({bufWe, bufAddr, bufData} !== {1'b1, 12'd0, 8'h55}) begin
         n_fail++;
         $display("FAIL abort_restart: we=%b addr=%h data=%h required 1 000 55", bufWe, bufAddr, bufData);
      end
      cs_off();
      clear_errs();
   endtask

   task automatic test_overrun();
      clear_log();
      do_full_load();
      send_byte(8'h99);
      idle(1);
      n_checks++;
      if (wq_addr.size() !== 8 || errOverrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_extra: writes=%0d errOverrun=%b required 8/1", wq_addr.size(), errOverrun);
      end
      cs_off();
      clear_errs();
      clear_log();
      engineBusy = 1'b1;
      cs_on();
      send_byte(8'hA5);
      send_byte(8'h01);
      idle(1);
      n_checks++;
      if (wq_addr.size() !== 0 || errOverrun !== 1'b1 || dut.state !== DRAIN || frameValid !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_busy: writes=%0d errOverrun=%b state=%0d fv=%b required 0/1/DRAIN/1",
                  wq_addr.size(), errOverrun, dut.state, frameValid);
      end
      engineBusy = 1'b0;
      cs_off();
      clear_errs();
   endtask

   task automatic test_unknown_cmd();
      clear_log();
      cs_on();
      send_byte(8'h33);
      idle(1);
      n_checks++;
      if ({errAbort, errOverrun, errStart} !== 3'b000 || dut.state !== DRAIN) begin
         n_fail++;
         $display("FAIL unknown_cmd: errs=%b%b%b state=%0d required 000/DRAIN", errAbort, errOverrun, errStart, dut.state);
      end
      send_byte(8'h44);
      send_byte(8'h45);
      idle(1);
      n_checks++;
      if (wq_addr.size() !== 0 || errAbort !== 1'b0 || errStart !== 1'b0) begin
         n_fail++;
         $display("FAIL unknown_data: writes=%0d errAbort=%b errStart=%b required 0/0/0", wq_addr.size(), errAbort, errStart);
      end
      clear_errs();
      errClear = 1'b1;
      send_byte(8'h46);
      errClear = 1'b0;
      idle(1);
      n_checks++;
      if (errOverrun !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_priority: errOverrun=%b required 0", errOverrun);
      end
      cs_off();
   endtask

   task automatic test_reset_mid_load();
      clear_log();
      cs_on();
      send_byte(8'hA5);
      for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i));
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({bufWe, bufAddr, bufData, frameValid, engineStart, loading, errAbort, errOverrun, errStart} !== 28'h0
          || dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL async_reset: we=%b addr=%h data=%h fv=%b ld=%b state=%0d required all 0/IDLE",
                  bufWe, bufAddr, bufData, frameValid, loading, dut.state);
      end
      csActive = 1'b0;
      idle(1);
      rst = 1'b0;
      idle(1);
      cs_on();
      send_byte(8'hA5);
      send_byte(8'h77);
      n_checks++;
      if ({bufWe, bufAddr, bufData} !== {1'b1, 12'd0, 8'h77}) begin
         n_fail++;
         $display("FAIL reset_reload: we=%b addr=%h data=%h required 1 000 77", bufWe, bufAddr, bufData);
      end
      cs_off();
      clear_errs();
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      n_starts   = 0;
      rst        = 1'b1;
      byteValid  = 1'b0;
      rxByte     = 8'h00;
      csActive   = 1'b0;
      engineBusy = 1'b0;
      errClear   = 1'b0;
      test_reset();
      test_full_load();
      test_start();
      test_abort();
      test_overrun();
      test_unknown_cmd();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
